shift_rs_ctrl: RTL and testbench

Single-entry reservation-station controller that sequences one `shifter` functional unit in the Tomasulo back end. It accepts a shift op from dispatch and snoops the common data buses for pending source operands. When both operands are valid it fires the shifter for exactly one cycle, then holds the entry until the shifter's own tag has been broadcast. One `shift_rs_ctrl` pairs with one `shifter`, and both share the same `TAG`.

---
 rtl/data_types.sv | 46 ++++
 rtl/cdb_snoop.sv | 35 +++
 rtl/shift_rs_ctrl.sv | 163 ++++++++++++++++
 tb/tb_shift_rs_ctrl.sv | 337 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/data_types.sv
// -----------------------------------------------------------------------------
// data_types
// Shared back-end types for the Tomasulo core: 32-bit data words, reservation
// station / result tags, shifter opcodes, CDB broadcast terms, and the state
// encoding of the shift reservation-station controller.
// No ports (package).
// -----------------------------------------------------------------------------
package data_types;

    typedef logic [31:0] word32_t;

    // NO_VAL marks "value already present"; it is never a real producer tag.
    typedef enum logic [2:0] {
        NO_VAL  = 3'd0,
        ALU_1   = 3'd1,
        ALU_2   = 3'd2,
        MUL_1   = 3'd3,
        MUL_2   = 3'd4,
        SHIFT_1 = 3'd5,
        SHIFT_2 = 3'd6,
        LOAD_1  = 3'd7
    } rs_tag_t;

    // Register (R) and immediate (I) forms of the three shifts.
    typedef enum logic [2:0] {
        SLLR = 3'd0,
        SRLR = 3'd1,
        SRAR = 3'd2,
        SLLI = 3'd3,
        SRLI = 3'd4,
        SRAI = 3'd5
    } shift_op_t;

    typedef struct packed {
        rs_tag_t tag;
        word32_t val;
    } cdb_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        FIRE  = 2'd2,
        BCAST = 2'd3
    } shift_rs_state_t;

endpackage

// File: rtl/cdb_snoop.sv
// -----------------------------------------------------------------------------
// cdb_snoop
// Compares one pending producer tag against every CDB term and returns the
// value of the lowest-index match.
//   q      in  : producer tag being waited on (NO_VAL = nothing pending)
//   cdb_i  in  : NUM_CDB broadcast terms
//   hit    out : some term carries tag q
//   val    out : value of the lowest-index matching term ('0 when no hit)
// -----------------------------------------------------------------------------
module cdb_snoop
    import data_types::*;
#(
    parameter int NUM_CDB = 4
) (
    input  rs_tag_t q,
    input  cdb_t    cdb_i [NUM_CDB],
    output logic    hit,
    output word32_t val
);

    // Tags are unique by construction, but a priority scan keeps the result
    // well defined anyway. Requiring q != NO_VAL also guarantees an idle CDB
    // term (tag NO_VAL) can never match.
    always_comb begin
        hit = 1'b0;
        val = '0;
        for (int k = 0; k < NUM_CDB; k++) begin
            if (!hit && (q != NO_VAL) && (cdb_i[k].tag == q)) begin
                hit = 1'b1;
                val = cdb_i[k].val;
            end
        end
    end

endmodule

// File: rtl/shift_rs_ctrl.sv
// -----------------------------------------------------------------------------
// shift_rs_ctrl
// Single-entry reservation station sequencing one shifter unit. Accepts a shift
// op from dispatch, snoops the CDBs for missing operands, pulses fu_ready_o for
// one cycle once both operands are present, then waits out the shifter's own
// broadcast cycle before the entry frees up.
//   clk_i, rst_ni      : clock, asynchronous active-low reset
//   flush_i            : squash the held op (synchronous)
//   disp_valid_i       : dispatch request
//   disp_ready_o       : entry can take a dispatch this cycle
//   disp_op_i          : shift operation
//   disp_q1_i/q2_i     : producer tags (NO_VAL = value valid)
//   disp_v1_i/v2_i     : operand values (v2 holds the immediate for I forms)
//   cdb_i              : NUM_CDB broadcast terms
//   fu_oper_o          : shifter operation
//   fu_rs1_o/fu_rs2_o  : shifter operands
//   fu_ready_o         : shifter start strobe
//   busy_o             : entry occupied
// -----------------------------------------------------------------------------
module shift_rs_ctrl
    import data_types::*;
#(
    parameter rs_tag_t TAG     = SHIFT_1,
    parameter int      NUM_CDB = 4
) (
    input  logic      clk_i,
    input  logic      rst_ni,
    input  logic      flush_i,
    input  logic      disp_valid_i,
    output logic      disp_ready_o,
    input  shift_op_t disp_op_i,
    input  rs_tag_t   disp_q1_i,
    input  rs_tag_t   disp_q2_i,
    input  word32_t   disp_v1_i,
    input  word32_t   disp_v2_i,
    input  cdb_t      cdb_i [NUM_CDB],
    output shift_op_t fu_oper_o,
    output word32_t   fu_rs1_o,
    output word32_t   fu_rs2_o,
    output logic      fu_ready_o,
    output logic      busy_o
);

    // A station tagged NO_VAL would look "always ready" to its consumers.
    if (TAG == NO_VAL) begin : g_bad_tag
        $error("shift_rs_ctrl: TAG must not be NO_VAL");
    end

    shift_rs_state_t state_q, state_d;

    shift_op_t op_q;
    rs_tag_t   q1_q, q2_q;
    word32_t   v1_q, v2_q;

    logic      disp_acc;
    rs_tag_t   q1_sel, q2_sel;
    rs_tag_t   q1_d, q2_d;
    word32_t   v1_d, v2_d;
    logic      hit1, hit2;
    word32_t   snoop_v1, snoop_v2;
    logic      opnds_ready;

    assign disp_acc = disp_valid_i && disp_ready_o;

    // The snoopers look at the incoming dispatch tags in the accept cycle
    // (same-cycle bypass, including our own BCAST result) and at the held
    // tags otherwise.
    always_comb begin
        q1_sel = disp_acc ? disp_q1_i : q1_q;
        q2_sel = disp_acc ? disp_q2_i : q2_q;
    end

    cdb_snoop #(.NUM_CDB(NUM_CDB)) u_snoop1 (
        .q     (q1_sel),
        .cdb_i (cdb_i),
        .hit   (hit1),
        .val   (snoop_v1)
    );

    cdb_snoop #(.NUM_CDB(NUM_CDB)) u_snoop2 (
        .q     (q2_sel),
        .cdb_i (cdb_i),
        .hit   (hit2),
        .val   (snoop_v2)
    );

    always_comb begin
        q1_d = hit1 ? NO_VAL : q1_sel;
        q2_d = hit2 ? NO_VAL : q2_sel;
        v1_d = hit1 ? snoop_v1 : (disp_acc ? disp_v1_i : v1_q);
        v2_d = hit2 ? snoop_v2 : (disp_acc ? disp_v2_i : v2_q);
        opnds_ready = (q1_d == NO_VAL) && (q2_d == NO_VAL);
    end

    // State register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        if (flush_i) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE, BCAST: begin
                    if (disp_acc) begin
                        state_d = opnds_ready ? FIRE : WAIT;
                    end else begin
                        state_d = IDLE;
                    end
                end
                WAIT: begin
                    if (opnds_ready) begin
                        state_d = FIRE;
                    end
                end
                FIRE:    state_d = BCAST;
                default: state_d = IDLE;
            endcase
        end
    end

    // Outputs; flush gates the strobe and the dispatch handshake in-cycle.
    always_comb begin
        fu_ready_o   = (state_q == FIRE) && !flush_i;
        disp_ready_o = ((state_q == IDLE) || (state_q == BCAST)) && !flush_i;
        busy_o       = (state_q != IDLE);
    end

    // Operand registers: loaded on dispatch, updated by wakeups in WAIT.
    // Values are kept across a flush; only the tags are cleared.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            op_q <= shift_op_t'(0);
            q1_q <= NO_VAL;
            q2_q <= NO_VAL;
            v1_q <= '0;
            v2_q <= '0;
        end else if (flush_i) begin
            q1_q <= NO_VAL;
            q2_q <= NO_VAL;
        end else if (disp_acc || (state_q == WAIT)) begin
            if (disp_acc) begin
                op_q <= disp_op_i;
            end
            q1_q <= q1_d;
            q2_q <= q2_d;
            v1_q <= v1_d;
            v2_q <= v2_d;
        end
    end

    assign fu_oper_o = op_q;
    assign fu_rs1_o  = v1_q;
    assign fu_rs2_o  = v2_q;

endmodule

// File: tb/tb_shift_rs_ctrl.sv
// -----------------------------------------------------------------------------
// tb_shift_rs_ctrl
// Bench for shift_rs_ctrl with a behavioural shifter closing the loop: the
// shifter's result is driven on cdb[3] in the cycle after fu_ready. Expected
// results are queued when an op is dispatched and popped when the shifter
// broadcasts.
// -----------------------------------------------------------------------------
module tb_shift_rs_ctrl;
    import data_types::*;

    localparam int NCDB = 4;

    logic      clk;
    logic      rst_n;
    logic      flush;
    logic      disp_valid;
    logic      disp_ready;
    shift_op_t disp_op;
    rs_tag_t   disp_q1, disp_q2;
    word32_t   disp_v1, disp_v2;
    cdb_t      cdb_drv [NCDB];
    cdb_t      cdb     [NCDB];
    shift_op_t fu_oper;
    word32_t   fu_rs1, fu_rs2;
    logic      fu_ready;
    logic      busy;

    rs_tag_t   sh_tag;
    word32_t   sh_val;

    int        n_chk  = 0;
    int        n_fail = 0;
    word32_t   sb [$];
    word32_t   exp_v;
    logic      prev_rdy;

    shift_rs_ctrl #(.TAG(SHIFT_1), .NUM_CDB(NCDB)) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .flush_i      (flush),
        .disp_valid_i (disp_valid),
        .disp_ready_o (disp_ready),
        .disp_op_i    (disp_op),
        .disp_q1_i    (disp_q1),
        .disp_q2_i    (disp_q2),
        .disp_v1_i    (disp_v1),
        .disp_v2_i    (disp_v2),
        .cdb_i        (cdb),
        .fu_oper_o    (fu_oper),
        .fu_rs1_o     (fu_rs1),
        .fu_rs2_o     (fu_rs2),
        .fu_ready_o   (fu_ready),
        .busy_o       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic word32_t shift_ref(input shift_op_t op, input word32_t a, input word32_t b);
        case (op)
            SLLR, SLLI: return a << b[4:0];
            SRLR, SRLI: return a >> b[4:0];
            default:    return word32_t'($signed(a) >>> b[4:0]);
        endcase
    endfunction

    // Behavioural shifter: registered, result on the CDB the cycle after ready.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_tag <= NO_VAL;
            sh_val <= '0;
        end else if (fu_ready) begin
            sh_tag <= SHIFT_1;
            sh_val <= shift_ref(fu_oper, fu_rs1, fu_rs2);
        end else begin
            sh_tag <= NO_VAL;
        end
    end

    always_comb begin
        for (int k = 0; k < NCDB; k++) cdb[k] = cdb_drv[k];
        if (sh_tag != NO_VAL) cdb[3] = '{tag: sh_tag, val: sh_val};
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Result scoreboard and strobe-spacing monitor.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_rdy <= 1'b0;
        end else begin
            check("fu_rdy_b2b", 32'(prev_rdy & fu_ready), 32'd0);
            prev_rdy <= fu_ready;
            if (sh_tag == SHIFT_1) begin
                if (sb.size() == 0) begin
                    check("unexp_bcast", 32'd1, 32'd0);
                end else begin
                    exp_v = sb.pop_front();
                    check("result", sh_val, exp_v);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        disp_valid = 1'b0;
        flush      = 1'b0;
        for (int k = 0; k < NCDB; k++) cdb_drv[k] = '{tag: NO_VAL, val: '0};
    endtask

    task automatic drive_disp(input shift_op_t op, input rs_tag_t q1, input word32_t v1,
                              input rs_tag_t q2, input word32_t v2);
        disp_valid = 1'b1;
        disp_op    = op;
        disp_q1    = q1;
        disp_v1    = v1;
        disp_q2    = q2;
        disp_v2    = v2;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n   = 1'b0;
        disp_op = SLLR;
        disp_q1 = NO_VAL;
        disp_q2 = NO_VAL;
        disp_v1 = '0;
        disp_v2 = '0;
        idle_inputs();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_disp_ready", 32'(disp_ready), 32'd1);
        check("rst_busy",       32'(busy),       32'd0);
        check("rst_fu_ready",   32'(fu_ready),   32'd0);
        check("rst_fu_oper",    32'(fu_oper),    32'd0);
        check("rst_rs1",        fu_rs1,          32'd0);
        check("rst_rs2",        fu_rs2,          32'd0);
        rst_n = 1'b1;
        tick();

        // 1: ready operands, SRLI 0x8000_0000 >> 4
        drive_disp(SRLI, NO_VAL, 32'h8000_0000, NO_VAL, 32'd4);
        sb.push_back(32'h0800_0000);
        @(negedge clk);
        check("t1_disp_ready", 32'(disp_ready), 32'd1);
        tick();
        disp_valid = 1'b0;
        @(negedge clk);
        check("t1_fire",  32'(fu_ready), 32'd1);
        check("t1_rs1",   fu_rs1, 32'h8000_0000);
        check("t1_rs2",   fu_rs2, 32'd4);
        check("t1_oper",  32'(fu_oper), 32'(SRLI));
        tick();
        @(negedge clk);
        check("t1_bcast_tag", 32'(sh_tag), 32'(SHIFT_1));
        check("t1_bcast_rdy", 32'(fu_ready), 32'd0);
        check("t1_bcast_busy", 32'(busy), 32'd1);
        tick();
        @(negedge clk);
        check("t1_idle", 32'(busy), 32'd0);

        // 2: wakeup of rs1 via cdb[2] three cycles after dispatch
        drive_disp(SLLR, ALU_1, 32'd0, NO_VAL, 32'd3);
        sb.push_back(32'h8);
        tick();
        disp_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("t2_wait_rdy",  32'(fu_ready), 32'd0);
            check("t2_wait_disp", 32'(disp_ready), 32'd0);
            tick();
        end
        cdb_drv[2] = '{tag: ALU_1, val: 32'h1};
        @(negedge clk);
        check("t2_wake_rdy", 32'(fu_ready), 32'd0);
        tick();
        idle_inputs();
        @(negedge clk);
        check("t2_fire", 32'(fu_ready), 32'd1);
        check("t2_rs1",  fu_rs1, 32'h1);
        check("t2_rs2",  fu_rs2, 32'd3);
        tick();
        tick();

        // 3: both operands woken in the same cycle from cdb[0] and cdb[3]
        drive_disp(SRAR, ALU_1, 32'd0, MUL_1, 32'd0);
        sb.push_back(32'hFF00_0000);
        tick();
        disp_valid = 1'b0;
        cdb_drv[0] = '{tag: ALU_1, val: 32'hF000_0000};
        cdb_drv[3] = '{tag: MUL_1, val: 32'd4};
        @(negedge clk);
        check("t3_wait_rdy", 32'(fu_ready), 32'd0);
        tick();
        idle_inputs();
        @(negedge clk);
        check("t3_fire", 32'(fu_ready), 32'd1);
        check("t3_rs1",  fu_rs1, 32'hF000_0000);
        check("t3_rs2",  fu_rs2, 32'd4);
        tick();
        tick();

        // 4: back-to-back, second op bypasses our own broadcast
        drive_disp(SLLI, NO_VAL, 32'd2, NO_VAL, 32'd3);
        sb.push_back(32'h10);
        tick();
        disp_valid = 1'b0;
        tick();
        drive_disp(SRLI, SHIFT_1, 32'd0, NO_VAL, 32'd1);
        sb.push_back(32'h8);
        @(negedge clk);
        check("t4_bcast_tag",  32'(sh_tag), 32'(SHIFT_1));
        check("t4_disp_ready", 32'(disp_ready), 32'd1);
        tick();
        disp_valid = 1'b0;
        @(negedge clk);
        check("t4_fire", 32'(fu_ready), 32'd1);
        check("t4_rs1",  fu_rs1, 32'h10);
        tick();
        tick();

        // 5: bypass at dispatch from cdb[1]
        drive_disp(SRLR, ALU_2, 32'd0, NO_VAL, 32'd2);
        cdb_drv[1] = '{tag: ALU_2, val: 32'h55};
        sb.push_back(32'h15);
        tick();
        idle_inputs();
        @(negedge clk);
        check("t5_fire", 32'(fu_ready), 32'd1);
        check("t5_rs1",  fu_rs1, 32'h55);
        tick();
        tick();

        // 6: flush in WAIT, stale tag must not wake the entry afterwards
        drive_disp(SLLR, ALU_1, 32'd0, NO_VAL, 32'd1);
        tick();
        disp_valid = 1'b0;
        @(negedge clk);
        check("t6_wait_busy", 32'(busy), 32'd1);
        tick();
        flush = 1'b1;
        @(negedge clk);
        check("t6_flush_rdy",  32'(fu_ready), 32'd0);
        check("t6_flush_disp", 32'(disp_ready), 32'd0);
        tick();
        flush = 1'b0;
        @(negedge clk);
        check("t6_idle", 32'(busy), 32'd0);
        cdb_drv[0] = '{tag: ALU_1, val: 32'h7};
        tick();
        idle_inputs();
        @(negedge clk);
        check("t6_stale_rdy",  32'(fu_ready), 32'd0);
        check("t6_stale_busy", 32'(busy), 32'd0);

        // 7: flush in FIRE forces fu_ready low in-cycle, no broadcast
        drive_disp(SLLI, NO_VAL, 32'd5, NO_VAL, 32'd1);
        tick();
        disp_valid = 1'b0;
        flush = 1'b1;
        @(negedge clk);
        check("t7_flush_rdy", 32'(fu_ready), 32'd0);
        tick();
        flush = 1'b0;
        @(negedge clk);
        check("t7_idle", 32'(busy), 32'd0);
        tick();

        // 8: flush with dispatch in IDLE: dispatch ignored
        flush = 1'b1;
        drive_disp(SLLI, NO_VAL, 32'd1, NO_VAL, 32'd1);
        @(negedge clk);
        check("t8_disp_ready", 32'(disp_ready), 32'd0);
        tick();
        idle_inputs();
        @(negedge clk);
        check("t8_idle", 32'(busy), 32'd0);

        // 9: flush in BCAST: broadcast still appears, dispatch ignored
        drive_disp(SRLI, NO_VAL, 32'h100, NO_VAL, 32'd4);
        sb.push_back(32'h10);
        tick();
        disp_valid = 1'b0;
        tick();
        flush = 1'b1;
        drive_disp(SLLI, NO_VAL, 32'd1, NO_VAL, 32'd1);
        @(negedge clk);
        check("t9_disp_ready", 32'(disp_ready), 32'd0);
        tick();
        idle_inputs();
        @(negedge clk);
        check("t9_idle", 32'(busy), 32'd0);
        check("t9_rdy",  32'(fu_ready), 32'd0);

        // 10: asynchronous reset during FIRE
        drive_disp(SRAI, NO_VAL, 32'hDEAD_BEEF, NO_VAL, 32'd5);
        tick();
        disp_valid = 1'b0;
        @(negedge clk);
        check("t10_fire", 32'(fu_ready), 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        check("t10_rst_rdy",  32'(fu_ready), 32'd0);
        check("t10_rst_busy", 32'(busy), 32'd0);
        check("t10_rst_disp", 32'(disp_ready), 32'd1);
        check("t10_rst_oper", 32'(fu_oper), 32'd0);
        check("t10_rst_rs1",  fu_rs1, 32'd0);
        check("t10_rst_rs2",  fu_rs2, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        tick();
        @(negedge clk);
        check("sb_empty", 32'(sb.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
